gate_eval_sequencer: RTL and testbench
======================================

Name: gate_eval_sequencer

Overview:
Exhaustive truth-table sequencer for the lab's combinational gate circuits (absorption, XOR, product-of-sums parts). On start, it drives every input combination in ascending order onto one DUT instance and waits a programmable settle time per vector. It then captures the DUT output into a truth-table register and compares it against an expected mask. It sits between the board switches/buttons and the gate circuit, and reports busy/done/pass plus a mismatch count to LEDs.

Parameters:
N_INPUTS, 3, number of DUT inputs (1..4); vector count V = 2^N_INPUTS
SETTLE_CYCLES, 2, cycles each vector is held before sampling (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a full evaluation run, sampled in IDLE or DONE only
abort  input  1  terminate the run in progress, return to IDLE
expected  input  V  expected truth table; bit i = expected output for input vector i
dut_out  input  1  DUT output
dut_in  output  N_INPUTS  vector applied to DUT; bit0 = input1, bit1 = input2, bit2 = input3
busy  output  1  high in DRIVE and SAMPLE
done  output  1  high in DONE, held until next start/abort/reset
pass  output  1  done & (mismatch_count == 0)
truth_table  output  V  captured DUT responses, bit i = response to vector i
mismatch_count  output  N_INPUTS+1  number of vectors where dut_out != expected bit

Behaviour:
- One clock; reset is synchronous and active-high; all state changes on rising clk.
- Reset (any state, including mid-run): state=IDLE; dut_in=0, busy=0, done=0, pass=0, truth_table=0, mismatch_count=0, settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: outputs hold. If start=1: dut_in<=0, truth_table<=0, mismatch_count<=0, settle_cnt<=SETTLE_CYCLES-1, go to DRIVE.
- DRIVE: dut_in held stable. If settle_cnt==0, go to SAMPLE; otherwise settle_cnt decrements. Lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - truth_table[dut_in] <= dut_out.
  - If dut_out != expected[dut_in], mismatch_count increments (saturation impossible: max = V).
  - If dut_in == V-1: go to DONE, dut_in holds V-1.
  - Otherwise dut_in increments, settle_cnt reloads to SETTLE_CYCLES-1, go to DRIVE.
- DONE: done=1; truth_table and mismatch_count frozen. start=1 restarts exactly as from IDLE (done drops on that edge).
- Latency: done rises V*(SETTLE_CYCLES+1)+1 rising edges after the edge that samples start. Defaults give 25 edges.
- busy and done are registered state decodes; they are never both high.
- Start while busy is ignored, with no restart and no effect on counters.
- Abort:
  - In DRIVE/SAMPLE: go to IDLE. busy=0, done=0. truth_table and mismatch_count keep partial values; dut_in holds.
  - In IDLE/DONE: go to IDLE and clear done.
  - abort has priority over start on the same edge.
- expected is sampled per-vector in SAMPLE. Changing it mid-run affects only the remaining vectors.
- dut_out is assumed combinationally derived from dut_in. Sampling only in SAMPLE guarantees at least SETTLE_CYCLES of settling.

Test Plan:
1. N=3, DUT=(a'+b')(a+c'), expected=8'h27, start pulse -> dut_in steps 0..7, each held 3 cycles. done at edge 25, truth_table=8'h27, mismatch_count=0, pass=1.
2. N=2, DUT=XOR (c'd+cd'), expected=4'h6 -> truth_table=4'h6, pass=1. Rerun with expected=4'hA -> mismatch_count=2, pass=0.
3. N=2, DUT=a+ab vs expected=4'hA (absorption) -> truth_table=4'hA, pass=1. Then start in DONE -> done drops next edge, truth_table cleared, run repeats.
4. Start pulses while busy at cycles 3 and 10 -> ignored; done still at edge 25. Abort at cycle 8 -> IDLE, busy=0, done=0, truth_table holds partial bits 0..1.
5. Reset asserted at cycle 12 mid-run -> next edge all outputs 0, state IDLE. Start after release -> full run completes normally.
6. SETTLE_CYCLES=1, N=1, DUT=NOT, expected=2'b01 -> done at edge 5, truth_table=2'b01, pass=1. Simultaneous start+abort in IDLE -> stays IDLE.

Source files
------------

// File: rtl/gate_eval_sequencer.sv
// Walks every input combination of a small gate circuit, holds each one for a
// settle time, captures the response into a truth table and counts mismatches.
module gate_eval_sequencer #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [(1<<N_INPUTS)-1:0]     expected,
  input  logic                         dut_out,
  output logic [N_INPUTS-1:0]          dut_in,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [(1<<N_INPUTS)-1:0]     truth_table,
  output logic [N_INPUTS:0]            mismatch_count
);

  localparam int V  = 1 << N_INPUTS;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SW-1:0]       SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]       SETTLE_ONE  = SW'(1);
  localparam logic [N_INPUTS-1:0] IN_ONE      = N_INPUTS'(1);
  localparam logic [N_INPUTS-1:0] IN_LAST     = '1;
  localparam logic [N_INPUTS:0]   MIS_ONE     = (N_INPUTS + 1)'(1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;

  state_e              state_q;
  logic [N_INPUTS-1:0] dut_in_q;
  logic [V-1:0]        truth_q;
  logic [N_INPUTS:0]   mis_q;
  logic [SW-1:0]       settle_q;
  logic                busy_q;
  logic                done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dut_in_q <= '0;
      truth_q  <= '0;
      mis_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (abort) begin
      // Partial results and the last applied vector stay visible after an abort.
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dut_in_q <= '0;
            truth_q  <= '0;
            mis_q    <= '0;
            settle_q <= SETTLE_LOAD;
            state_q  <= DRIVE;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_q == '0) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q - SETTLE_ONE;
          end
        end
        SAMPLE: begin
          truth_q[dut_in_q] <= dut_out;
          if (dut_out != expected[dut_in_q]) begin
            mis_q <= mis_q + MIS_ONE;
          end
          if (dut_in_q == IN_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            dut_in_q <= dut_in_q + IN_ONE;
            settle_q <= SETTLE_LOAD;
            state_q  <= DRIVE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign truth_table    = truth_q;
  assign mismatch_count = mis_q;
  assign pass           = done_q & (mis_q == '0);

endmodule

// File: tb/tb_gate_eval_sequencer.sv
// Directed bench for gate_eval_sequencer: three instances cover N=3/S=2,
// N=2/S=2 and N=1/S=1 with lab gate circuits modelled as bench-side logic.
module tb_gate_eval_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  logic       start3, abort3, out3, busy3, done3, pass3;
  logic [7:0] exp3, tt3;
  logic [2:0] in3;
  logic [3:0] mis3;

  logic       start2, abort2, out2, busy2, done2, pass2, mode2;
  logic [3:0] exp2, tt2;
  logic [1:0] in2;
  logic [2:0] mis2;

  logic       start1, abort1, out1, busy1, done1, pass1;
  logic [1:0] exp1, tt1;
  logic [0:0] in1;
  logic [1:0] mis1;

  gate_eval_sequencer #(.N_INPUTS(3), .SETTLE_CYCLES(2)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3), .expected(exp3),
    .dut_out(out3), .dut_in(in3), .busy(busy3), .done(done3), .pass(pass3),
    .truth_table(tt3), .mismatch_count(mis3));

  gate_eval_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2), .expected(exp2),
    .dut_out(out2), .dut_in(in2), .busy(busy2), .done(done2), .pass(pass2),
    .truth_table(tt2), .mismatch_count(mis2));

  gate_eval_sequencer #(.N_INPUTS(1), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .expected(exp1),
    .dut_out(out1), .dut_in(in1), .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tt1), .mismatch_count(mis1));

  // Gate circuits under evaluation: (a'+b')(a+c'), XOR / absorption a+ab, NOT.
  assign out3 = (~in3[0] | ~in3[1]) & (in3[0] | ~in3[2]);
  assign out2 = mode2 ? (in2[0] | (in2[0] & in2[1])) : ((~in2[0] & in2[1]) | (in2[0] & ~in2[1]));
  assign out1 = ~in1[0];

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] required);
    vecCount++;
    if (observed !== required) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, required);
    end
  endtask

  // Edge k=0 is the edge that samples start; done lands on k = V*(S+1),
  // i.e. edge 25 for the default build when the start edge is counted as 1.
  initial begin
    reset = 1'b1;
    {start3, abort3, start2, abort2, start1, abort1, mode2} = '0;
    exp3 = 8'h27; exp2 = 4'h6; exp1 = 2'b01;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    applyStimulus();

    checkOutput("rst dut_in", in3, 0);
    checkOutput("rst busy", busy3, 0);
    checkOutput("rst done", done3, 0);
    checkOutput("rst pass", pass3, 0);
    checkOutput("rst truth", tt3, 0);
    checkOutput("rst mis", mis3, 0);

    // Plain run of the product-of-sums circuit.
    start3 = 1'b1;
    applyStimulus();
    start3 = 1'b0;
    checkOutput("t1 busy k0", busy3, 1);
    for (int k = 1; k <= 24; k++) begin
      applyStimulus();
      if (k % 3 == 1) checkOutput("t1 dut_in", in3, k / 3);
      if (k == 23) checkOutput("t1 done early", done3, 0);
    end
    checkOutput("t1 done", done3, 1);
    checkOutput("t1 busy", busy3, 0);
    checkOutput("t1 truth", tt3, 8'h27);
    checkOutput("t1 mis", mis3, 0);
    checkOutput("t1 pass", pass3, 1);
    checkOutput("t1 dut_in last", in3, 7);

    // Restart from DONE, with start pulses while busy that must be ignored.
    start3 = 1'b1;
    applyStimulus();
    start3 = 1'b0;
    checkOutput("t4 restart done", done3, 0);
    checkOutput("t4 restart truth", tt3, 0);
    checkOutput("t4 restart busy", busy3, 1);
    for (int k = 1; k <= 24; k++) begin
      start3 = (k == 3) || (k == 10);
      applyStimulus();
      if (k == 23) checkOutput("t4 done early", done3, 0);
    end
    start3 = 1'b0;
    checkOutput("t4 done", done3, 1);
    checkOutput("t4 truth", tt3, 8'h27);

    // Abort during the third vector's settle window.
    start3 = 1'b1;
    applyStimulus();
    start3 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      abort3 = (k == 8);
      applyStimulus();
    end
    abort3 = 1'b0;
    checkOutput("t4 abort busy", busy3, 0);
    checkOutput("t4 abort done", done3, 0);
    checkOutput("t4 abort truth", tt3, 8'h03);
    checkOutput("t4 abort mis", mis3, 0);
    checkOutput("t4 abort dut_in", in3, 2);
    repeat (4) applyStimulus();
    checkOutput("t4 idle hold", tt3, 8'h03);
    checkOutput("t4 idle busy", busy3, 0);

    // Reset in the middle of a run, then a clean run.
    start3 = 1'b1;
    applyStimulus();
    start3 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      reset = (k == 12);
      applyStimulus();
      if (k == 11) checkOutput("t5 partial truth", tt3, 8'h07);
    end
    reset = 1'b0;
    checkOutput("t5 rst dut_in", in3, 0);
    checkOutput("t5 rst busy", busy3, 0);
    checkOutput("t5 rst truth", tt3, 0);
    checkOutput("t5 rst mis", mis3, 0);
    start3 = 1'b1;
    applyStimulus();
    start3 = 1'b0;
    repeat (24) applyStimulus();
    checkOutput("t5 done", done3, 1);
    checkOutput("t5 pass", pass3, 1);

    // XOR circuit, matching and non-matching expected tables.
    mode2 = 1'b0;
    exp2  = 4'h6;
    start2 = 1'b1;
    applyStimulus();
    start2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus();
      if (k == 11) checkOutput("t2 done early", done2, 0);
    end
    checkOutput("t2 done", done2, 1);
    checkOutput("t2 truth", tt2, 4'h6);
    checkOutput("t2 pass", pass2, 1);
    exp2 = 4'hA;
    start2 = 1'b1;
    applyStimulus();
    start2 = 1'b0;
    repeat (12) applyStimulus();
    checkOutput("t2b truth", tt2, 4'h6);
    checkOutput("t2b mis", mis2, 2);
    checkOutput("t2b pass", pass2, 0);
    checkOutput("t2b done", done2, 1);

    // Absorption circuit, then restart from DONE.
    mode2 = 1'b1;
    start2 = 1'b1;
    applyStimulus();
    start2 = 1'b0;
    repeat (12) applyStimulus();
    checkOutput("t3 truth", tt2, 4'hA);
    checkOutput("t3 pass", pass2, 1);
    start2 = 1'b1;
    applyStimulus();
    start2 = 1'b0;
    checkOutput("t3 restart done", done2, 0);
    checkOutput("t3 restart truth", tt2, 0);
    checkOutput("t3 restart busy", busy2, 1);
    repeat (12) applyStimulus();
    checkOutput("t3 rerun truth", tt2, 4'hA);
    checkOutput("t3 rerun pass", pass2, 1);

    // Single-input NOT with one settle cycle.
    start1 = 1'b1;
    applyStimulus();
    start1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus();
      if (k == 3) checkOutput("t6 done early", done1, 0);
    end
    checkOutput("t6 done", done1, 1);
    checkOutput("t6 truth", tt1, 2'b01);
    checkOutput("t6 pass", pass1, 1);
    abort1 = 1'b1;
    applyStimulus();
    checkOutput("t6 abort done", done1, 0);
    start1 = 1'b1;
    applyStimulus();
    {start1, abort1} = '0;
    checkOutput("t6 start+abort busy", busy1, 0);
    checkOutput("t6 start+abort done", done1, 0);
    checkOutput("t6 start+abort truth", tt1, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
